// File: rtl/match_controller.sv
// Best-of-N fight match sequencer: countdown, timed fight, round-end hold, match end.
// All outputs are registered; game_state reads 5 while a timed phase is frozen by pause.
module match_controller #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int COUNTDOWN_SEC  = 3,
  parameter int ROUND_SEC      = 99,
  parameter int END_HOLD_SEC   = 2,
  parameter int ROUNDS_TO_WIN  = 2,
  parameter int MAX_ROUNDS     = 5,
  parameter int HEALTH_W       = 3,
  parameter int TIME_W         = 7
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 pause,
  input  logic [HEALTH_W-1:0]                  p1_health,
  input  logic [HEALTH_W-1:0]                  p2_health,
  output logic [2:0]                           game_state,
  output logic [$clog2(MAX_ROUNDS+1)-1:0]      round_num,
  output logic [$clog2(ROUNDS_TO_WIN+1)-1:0]   p1_wins,
  output logic [$clog2(ROUNDS_TO_WIN+1)-1:0]   p2_wins,
  output logic [TIME_W-1:0]                    seconds_left,
  output logic                                 round_reset,
  output logic [1:0]                           round_winner,
  output logic [1:0]                           match_winner
);
  localparam int RW  = $clog2(MAX_ROUNDS+1);
  localparam int WW  = $clog2(ROUNDS_TO_WIN+1);
  localparam int FCW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_CD = 3'd1, S_FIGHT = 3'd2, S_REND = 3'd3, S_MEND = 3'd4
  } state_t;
  localparam logic [2:0] GS_PAUSED = 3'd5;

  state_t            state_q, state_d;
  logic [FCW-1:0]    fc_q, fc_d;
  logic [TIME_W-1:0] sec_q, sec_d;
  logic [RW-1:0]     rnd_q, rnd_d;
  logic [WW-1:0]     p1w_q, p1w_d, p2w_q, p2w_d;
  logic [1:0]        rw_q, rw_d, mw_q, mw_d;
  logic              rr_q, rr_d;
  logic [2:0]        gs_q, gs_d;
  logic              run, wrap, expire;
  logic              ko1, ko2;
  logic [1:0]        res;

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    sec_d   = sec_q;
    rnd_d   = rnd_q;
    p1w_d   = p1w_q;
    p2w_d   = p2w_q;
    rw_d    = rw_q;
    mw_d    = mw_q;
    rr_d    = 1'b0;
    res     = 2'b00;
    ko1     = (p1_health == '0);
    ko2     = (p2_health == '0);
    wrap    = (fc_q == FCW'(FRAMES_PER_SEC-1));
    expire  = wrap && (sec_q == TIME_W'(1));
    run     = ((state_q == S_CD || state_q == S_FIGHT) && !pause) || (state_q == S_REND);

    // Free-running frame/second tick; transitions below override it.
    if (run) begin
      fc_d = wrap ? '0 : fc_q + FCW'(1);
      if (wrap) sec_d = sec_q - TIME_W'(1);
    end

    case (state_q)
      S_IDLE, S_MEND: begin
        if (start) begin
          state_d = S_CD;
          rnd_d   = RW'(1);
          p1w_d   = '0;
          p2w_d   = '0;
          rw_d    = 2'b00;
          mw_d    = 2'b00;
          sec_d   = TIME_W'(COUNTDOWN_SEC);
          fc_d    = '0;
          rr_d    = 1'b1;
        end
      end
      S_CD: begin
        if (!pause && expire) begin
          state_d = S_FIGHT;
          sec_d   = TIME_W'(ROUND_SEC);
          fc_d    = '0;
        end
      end
      S_FIGHT: begin
        if (!pause) begin
          // KO outranks timeout when both land on the same cycle.
          if (ko1 && ko2)                res = 2'b11;
          else if (ko1)                  res = 2'b10;
          else if (ko2)                  res = 2'b01;
          else if (expire)               res = (p1_health > p2_health) ? 2'b01 :
                                               (p2_health > p1_health) ? 2'b10 : 2'b11;
          if (res != 2'b00) begin
            state_d = S_REND;
            sec_d   = TIME_W'(END_HOLD_SEC);
            fc_d    = '0;
            rw_d    = res;
            if (res == 2'b01 && p1w_q != WW'(ROUNDS_TO_WIN)) p1w_d = p1w_q + WW'(1);
            if (res == 2'b10 && p2w_q != WW'(ROUNDS_TO_WIN)) p2w_d = p2w_q + WW'(1);
          end
        end
      end
      S_REND: begin
        if (expire) begin
          fc_d = '0;
          if (p1w_q == WW'(ROUNDS_TO_WIN) || p2w_q == WW'(ROUNDS_TO_WIN)
              || rnd_q == RW'(MAX_ROUNDS)) begin
            state_d = S_MEND;
            sec_d   = '0;
            mw_d    = (p1w_q > p2w_q) ? 2'b01 : (p2w_q > p1w_q) ? 2'b10 : 2'b11;
          end else begin
            state_d = S_CD;
            rnd_d   = rnd_q + RW'(1);
            sec_d   = TIME_W'(COUNTDOWN_SEC);
            rr_d    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    gs_d = (pause && (state_q == S_CD || state_q == S_FIGHT)) ? GS_PAUSED : 3'(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      fc_q    <= '0;
      sec_q   <= '0;
      rnd_q   <= '0;
      p1w_q   <= '0;
      p2w_q   <= '0;
      rw_q    <= 2'b00;
      mw_q    <= 2'b00;
      rr_q    <= 1'b0;
      gs_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      sec_q   <= sec_d;
      rnd_q   <= rnd_d;
      p1w_q   <= p1w_d;
      p2w_q   <= p2w_d;
      rw_q    <= rw_d;
      mw_q    <= mw_d;
      rr_q    <= rr_d;
      gs_q    <= gs_d;
    end
  end

  assign game_state   = gs_q;
  assign round_num    = rnd_q;
  assign p1_wins      = p1w_q;
  assign p2_wins      = p2w_q;
  assign seconds_left = sec_q;
  assign round_reset  = rr_q;
  assign round_winner = rw_q;
  assign match_winner = mw_q;
endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: round/match results are queued when the
// deciding stimulus is driven and checked when the DUT enters ROUND_END / MATCH_END.
module tb_match_controller;
  localparam int FPS = 4, CDS = 3, RS = 5, EHS = 1, RTW = 2, MR = 3, HW = 3, TW = 7;

  logic          clk = 1'b0;
  logic          rst, start, pause;
  logic [HW-1:0] p1_health, p2_health;
  logic [2:0]    gs;
  logic [1:0]    rnd, p1w, p2w;
  logic [TW-1:0] sl;
  logic          rr;
  logic [1:0]    rw, mw;

  match_controller #(
    .FRAMES_PER_SEC(FPS), .COUNTDOWN_SEC(CDS), .ROUND_SEC(RS), .END_HOLD_SEC(EHS),
    .ROUNDS_TO_WIN(RTW), .MAX_ROUNDS(MR), .HEALTH_W(HW), .TIME_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .p1_health(p1_health), .p2_health(p2_health),
    .game_state(gs), .round_num(rnd), .p1_wins(p1w), .p2_wins(p2w),
    .seconds_left(sl), .round_reset(rr), .round_winner(rw), .match_winner(mw)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_match;
    logic [1:0] win;
    logic [1:0] p1w;
    logic [1:0] p2w;
    logic [1:0] rnd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errs   = 0;
  logic [2:0] prev_gs = 3'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gs(input logic [2:0] tgt, input int budget, output int n);
    n = 0;
    while (gs !== tgt && n < budget) begin
      tick();
      n++;
    end
    chk("wait_gs", 32'(gs), 32'(tgt));
  endtask

  task automatic push_round(input logic [1:0] w, input logic [1:0] a, input logic [1:0] b,
                            input logic [1:0] r);
    exp_t e;
    e.is_match = 1'b0; e.win = w; e.p1w = a; e.p2w = b; e.rnd = r;
    sb.push_back(e);
  endtask

  task automatic push_match(input logic [1:0] w, input logic [1:0] a, input logic [1:0] b);
    exp_t e;
    e.is_match = 1'b1; e.win = w; e.p1w = a; e.p2w = b; e.rnd = 2'd0;
    sb.push_back(e);
  endtask

  // Result monitor: pops one expectation per ROUND_END / MATCH_END entry.
  always @(negedge clk) begin
    if (!rst && gs != prev_gs && (gs == 3'd3 || gs == 3'd4)) begin
      if (sb.size() == 0) chk("sb_unexpected_event", 32'(gs), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_kind", 32'(gs == 3'd4), 32'(e.is_match));
        if (e.is_match) chk("sb_match_winner", 32'(mw), 32'(e.win));
        else begin
          chk("sb_round_winner", 32'(rw), 32'(e.win));
          chk("sb_round_num", 32'(rnd), 32'(e.rnd));
        end
        chk("sb_p1_wins", 32'(p1w), 32'(e.p1w));
        chk("sb_p2_wins", 32'(p2w), 32'(e.p2w));
      end
    end
    prev_gs <= gs;
  end

  function automatic logic [31:0] all_outs();
    return 32'({gs, rnd, p1w, p2w, sl, rr, rw, mw});
  endfunction

  initial begin
    int n;
    logic [31:0] acc;
    int rr_cnt;
    rst = 1'b1; start = 1'b0; pause = 1'b0; p1_health = 3'd7; p2_health = 3'd7;

    // 1. reset, then idle with start low
    tick(); tick();
    chk("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    acc = '0; rr_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      acc |= all_outs();
      if (rr) rr_cnt++;
    end
    chk("idle_outs", acc, 32'd0);
    chk("idle_rr", rr_cnt, 0);

    // 2. countdown timing
    start = 1'b1; tick(); start = 1'b0;
    chk("cd_rr", 32'(rr), 32'd1);
    chk("cd_gs", 32'(gs), 32'd1);
    chk("cd_rnd", 32'(rnd), 32'd1);
    chk("cd_sl0", 32'(sl), 32'(CDS));
    for (int i = 1; i < 12; i++) begin
      tick();
      if (i == 1) chk("cd_rr_one_cycle", 32'(rr), 32'd0);
      chk("cd_sl", 32'(sl), 32'(CDS - i / FPS));
      chk("cd_gs_hold", 32'(gs), 32'd1);
    end
    tick();
    chk("fight_gs", 32'(gs), 32'd2);
    chk("fight_sl", 32'(sl), 32'(RS));

    // 3. KO rounds win the match for P1
    push_round(2'b01, 2'd1, 2'd0, 2'd1);
    p2_health = 3'd0; tick(); p2_health = 3'd7;
    chk("rend_sl", 32'(sl), 32'(EHS));
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("rend_hold", 32'(gs), 32'd3);
    end
    tick();
    chk("r2_gs", 32'(gs), 32'd1);
    chk("r2_rnd", 32'(rnd), 32'd2);
    chk("r2_rr", 32'(rr), 32'd1);
    wait_gs(3'd2, 20, n);
    chk("r2_cd_len", n, 12);
    push_round(2'b01, 2'd2, 2'd0, 2'd2);
    push_match(2'b01, 2'd2, 2'd0);
    p2_health = 3'd0; tick(); p2_health = 3'd7;
    wait_gs(3'd4, 10, n);
    chk("mend_sl", 32'(sl), 32'd0);
    tick(); tick();
    chk("mend_hold_mw", 32'(mw), 32'b01);

    // 4. simultaneous KO draw, then timeout draw on equal health
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_wins", 32'({p1w, p2w}), 32'd0);
    chk("restart_mw", 32'(mw), 32'd0);
    wait_gs(3'd2, 20, n);
    push_round(2'b11, 2'd0, 2'd0, 2'd1);
    p1_health = 3'd0; p2_health = 3'd0; tick(); p1_health = 3'd4; p2_health = 3'd4;
    wait_gs(3'd2, 40, n);
    push_round(2'b11, 2'd0, 2'd0, 2'd2);
    wait_gs(3'd3, 25, n);
    chk("timeout_len", n, FPS * RS);

    // 5. third draw hits the round cap
    wait_gs(3'd2, 40, n);
    push_round(2'b11, 2'd0, 2'd0, 2'd3);
    push_match(2'b11, 2'd0, 2'd0);
    p1_health = 3'd0; p2_health = 3'd0; tick(); p1_health = 3'd7; p2_health = 3'd7;
    wait_gs(3'd4, 10, n);
    start = 1'b1; tick(); start = 1'b0;
    chk("cap_restart_rnd", 32'(rnd), 32'd1);
    chk("cap_restart_wins", 32'({p1w, p2w}), 32'd0);
    chk("cap_restart_rw", 32'(rw), 32'd0);
    chk("cap_restart_rr", 32'(rr), 32'd1);

    // 6. pause mid-fight, then reset mid-fight
    wait_gs(3'd2, 20, n);
    chk("pause_cd_len", n, 12);
    tick(); tick();
    pause = 1'b1; p1_health = 3'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pause_gs", 32'(gs), 32'd5);
      chk("pause_sl", 32'(sl), 32'(RS));
    end
    pause = 1'b0; p1_health = 3'd7;
    tick();
    chk("resume_gs", 32'(gs), 32'd2);
    chk("resume_sl", 32'(sl), 32'(RS));
    tick();
    chk("resume_wrap_sl", 32'(sl), 32'(RS - 1));
    rst = 1'b1; tick();
    chk("midfight_reset", all_outs(), 32'd0);
    rst = 1'b0; tick();
    chk("post_reset_gs", 32'(gs), 32'd0);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
Parametrised successor to the fixed single-round game controller. Runs a best-of-N fighting match on the 60 Hz effective clock with this flow: pre-round countdown, timed fight, round-end hold, match end. Per-round and per-match winners come from the two players' health values. It drives `game_state` to the sprite ROM and HEX logic, and issues a `round_reset` pulse so both `player` instances and `health_status` return to spawn between rounds.

Parameters:
FRAMES_PER_SEC, 60, clk cycles per displayed second
COUNTDOWN_SEC, 3, pre-round countdown length in seconds
ROUND_SEC, 99, fight time limit in seconds
END_HOLD_SEC, 2, round-end / result display hold in seconds
ROUNDS_TO_WIN, 2, round wins needed to take the match
MAX_ROUNDS, 5, hard cap on rounds played (draws can consume rounds)
HEALTH_W, 3, health input width
TIME_W, 7, seconds counter width; must hold max(COUNTDOWN_SEC, ROUND_SEC, END_HOLD_SEC)

Ports:
clk  in  1  effective frame clock
rst  in  1  synchronous reset, active-high
start  in  1  level; sampled only in IDLE / MATCH_END
pause  in  1  level; freezes timing in COUNTDOWN / FIGHT
p1_health  in  HEALTH_W  player 1 health, 0 = KO
p2_health  in  HEALTH_W  player 2 health, 0 = KO
game_state  out  3  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_END, 4 MATCH_END, 5 PAUSED
round_num  out  $clog2(MAX_ROUNDS+1)  current round, 1-based; 0 in IDLE
p1_wins  out  $clog2(ROUNDS_TO_WIN+1)  rounds won by player 1
p2_wins  out  $clog2(ROUNDS_TO_WIN+1)  rounds won by player 2
seconds_left  out  TIME_W  remaining seconds of the current timed phase
round_reset  out  1  one-cycle pulse: reset players / health
round_winner  out  2  last round result: 00 none, 01 P1, 10 P2, 11 draw
match_winner  out  2  same encoding; valid in MATCH_END, else 00

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- `rst` has priority over everything. On reset: state IDLE, `game_state`=0, every counter and output 0, and `round_reset`=0.
- Frame counter `fc` runs 0..FRAMES_PER_SEC-1 in COUNTDOWN, FIGHT and ROUND_END.
  - A wrap is the cycle where `fc`=FRAMES_PER_SEC-1.
  - On a wrap, `seconds_left` decrements.
  - `fc` is cleared on every state entry.
- Phase expiry: the wrap cycle in which `seconds_left`=1. The transition happens on that edge, so `seconds_left` never shows 0 in a timed state.
- IDLE / MATCH_END + `start`=1:
  - Go to COUNTDOWN, `round_num`=1, wins cleared, `round_winner`=`match_winner`=00.
  - `seconds_left`=COUNTDOWN_SEC; `round_reset`=1 for exactly this transition cycle.
- COUNTDOWN expiry: go to FIGHT with `seconds_left`=ROUND_SEC.
- FIGHT: the round ends when the first of these holds, checked every cycle.
  - KO:
    - `p1_health`=0 and `p2_health`=0 on the same cycle: draw (11).
    - Only `p1_health`=0: P2 wins (10).
    - Only `p2_health`=0: P1 wins (01).
  - Timeout (expiry): the higher health wins; equal health is a draw.
  - KO takes priority over timeout on the same cycle.
  - Result: the winner's win count increments (saturating at ROUNDS_TO_WIN), `round_winner` is updated, go to ROUND_END, `seconds_left`=END_HOLD_SEC.
- ROUND_END expiry:
  - If a player has ROUNDS_TO_WIN wins: go to MATCH_END, `match_winner` = that player.
  - Else if `round_num`=MAX_ROUNDS: go to MATCH_END, `match_winner` = the player with more wins; equal wins gives 11.
  - Else: `round_num`++, `round_reset` pulse, go to COUNTDOWN with `seconds_left`=COUNTDOWN_SEC.
- MATCH_END: `seconds_left`=0; holds all results until `start`.
- `pause`=1 in COUNTDOWN or FIGHT:
  - `game_state` reads 5.
  - `fc`, `seconds_left` and KO detection freeze.
  - Internal state is retained; when `pause` falls, the phase resumes on the next cycle with the same `fc`.
- `pause` has no effect in IDLE, ROUND_END or MATCH_END.
- `start` is ignored outside IDLE / MATCH_END.
- Health inputs are ignored outside FIGHT, so residual 0 health from the previous round does not re-trigger a KO. `round_reset` restores health before FIGHT begins.
- All outputs are registered, with one-cycle latency from the deciding condition to the output.

Test Plan:
All scenarios use FRAMES_PER_SEC=4, COUNTDOWN_SEC=3, ROUND_SEC=5, END_HOLD_SEC=1, ROUNDS_TO_WIN=2, MAX_ROUNDS=3.
1. Reset then idle: `rst` for 2 cycles, `start`=0 for 20 cycles -> all outputs 0, `game_state`=0, no `round_reset` pulse.
2. Countdown timing: `start` pulse -> `round_reset`=1 for one cycle; `seconds_left` reads 3,2,1 with each value held 4 cycles; `game_state`=2 with `seconds_left`=5 exactly 12 cycles after the start edge.
3. KO wins match: in FIGHT drive `p2_health`=0 -> `round_winner`=01, `p1_wins`=1, ROUND_END for 4 cycles, `round_num`=2; repeat the KO -> `game_state`=4, `match_winner`=01, `p1_wins`=2.
4. Simultaneous KO and timeout draw: both healths 0 on the same cycle -> `round_winner`=11, no win awarded; next round hold healths 4/4 for 20 cycles -> timeout draw 11.
5. MAX_ROUNDS cap: play three draw rounds -> MATCH_END after round 3, `match_winner`=11; `start` then restarts with `round_num`=1 and wins 0.
6. Pause and mid-fight reset: `pause`=1 for 10 cycles mid-FIGHT -> `game_state`=5, `seconds_left` unchanged, KO ignored during the pause, timing resumes after `pause` falls; `rst` asserted mid-FIGHT -> IDLE, all outputs 0 on the next edge.
